ex_dm_pipe_stage: RTL and testbench

Parametrised EX→DM pipeline register for the 5-stage core: captures the execute-stage result bundle (ALU result as memory address, store data, destination register, memory/writeback controls) and presents it to the data-memory stage. Unlike the fixed single-register stage, it has a valid/ready handshake with a 2-entry skid buffer for back-pressure, a synchronous flush that inserts bubbles, and a saturating stall counter. It sits between the ALU/forwarding logic and the data memory/DM→WB register.

---
 rtl/ex_dm_pipe_stage_if.sv | 42 ++++
 rtl/ex_dm_pipe_stage.sv | 138 +++++++++++++
 tb/tb_ex_dm_pipe_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_dm_pipe_stage_if.sv
// EX->DM bundle interface: upstream valid/ready with the execute-stage bundle,
// downstream valid/ready with the captured data-memory bundle.
interface ex_dm_pipe_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_alu_result;
    logic [DATA_W-1:0]  in_write_data;
    logic [RADDR_W-1:0] in_rd;
    logic               in_mem_read;
    logic               in_mem_write;
    logic               in_mem_to_reg;
    logic               in_reg_write;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_mem_address;
    logic [DATA_W-1:0]  out_write_data;
    logic [RADDR_W-1:0] out_rd;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_mem_to_reg;
    logic               out_reg_write;

    modport master (
        output in_valid, in_alu_result, in_write_data, in_rd,
               in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
               out_ready,
        input  in_ready, out_valid, out_mem_address, out_write_data, out_rd,
               out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write
    );

    modport slave (
        input  in_valid, in_alu_result, in_write_data, in_rd,
               in_mem_read, in_mem_write, in_mem_to_reg, in_reg_write,
               out_ready,
        output in_ready, out_valid, out_mem_address, out_write_data, out_rd,
               out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write
    );
endinterface

// File: rtl/ex_dm_pipe_stage.sv
// EX->DM pipeline register with a 2-entry skid buffer, synchronous flush and a
// saturating count of back-pressured cycles.
module ex_dm_pipe_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    ex_dm_pipe_stage_if.slave bus,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic [RADDR_W-1:0] rd;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
    } entry_t;

    function automatic entry_t kill_ctrl(input entry_t e);
        entry_t r;
        r            = e;
        r.mem_read   = 1'b0;
        r.mem_write  = 1'b0;
        r.mem_to_reg = 1'b0;
        r.reg_write  = 1'b0;
        return r;
    endfunction

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_e;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic out_valid;
    logic in_ready;
    logic in_fire;
    logic out_fire;

    // Handshake outputs come from state flops only, so in_ready never
    // depends combinationally on out_ready or in_valid.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        in_e.addr       = bus.in_alu_result;
        in_e.wdata      = bus.in_write_data;
        in_e.rd         = bus.in_rd;
        in_e.mem_read   = bus.in_mem_read;
        in_e.mem_write  = bus.in_mem_write;
        in_e.mem_to_reg = bus.in_mem_to_reg;
        in_e.reg_write  = bus.in_reg_write;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = kill_ctrl(main_q);
            skid_d  = kill_ctrl(skid_q);
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_e;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_e;
                    end else if (in_fire) begin
                        skid_d  = in_e;
                        state_d = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !bus.out_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign bus.out_valid       = out_valid;
    assign bus.in_ready        = in_ready;
    assign bus.out_mem_address = main_q.addr;
    assign bus.out_write_data  = main_q.wdata;
    assign bus.out_rd          = main_q.rd;
    assign bus.out_mem_read    = main_q.mem_read   & out_valid;
    assign bus.out_mem_write   = main_q.mem_write  & out_valid;
    assign bus.out_mem_to_reg  = main_q.mem_to_reg & out_valid;
    assign bus.out_reg_write   = main_q.reg_write  & out_valid;
    assign stall_count         = stall_q;

endmodule

// File: tb/tb_ex_dm_pipe_stage.sv
// Directed bench for ex_dm_pipe_stage: streaming, skid back-pressure, flush,
// async reset and counter saturation on a narrow-counter instance.
module tb_ex_dm_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_a;
    logic        flush_b;
    logic [15:0] stall_a;
    logic [1:0]  stall_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ex_dm_pipe_stage_if #(.DATA_W(32), .RADDR_W(5)) bus_a ();
    ex_dm_pipe_stage_if #(.DATA_W(32), .RADDR_W(5)) bus_b ();

    ex_dm_pipe_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(16)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_a),
        .bus         (bus_a),
        .stall_count (stall_a)
    );

    ex_dm_pipe_stage #(.DATA_W(32), .RADDR_W(5), .CNT_W(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush_b),
        .bus         (bus_b),
        .stall_count (stall_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctrl order: {mem_read, mem_write, mem_to_reg, reg_write}
    task automatic drive_a(input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd, input logic [3:0] ctrl);
        bus_a.in_valid      = 1'b1;
        bus_a.in_alu_result = alu;
        bus_a.in_write_data = wd;
        bus_a.in_rd         = rd;
        {bus_a.in_mem_read, bus_a.in_mem_write,
         bus_a.in_mem_to_reg, bus_a.in_reg_write} = ctrl;
    endtask

    task automatic idle_a();
        bus_a.in_valid = 1'b0;
    endtask

    function automatic logic [3:0] ctrl_a();
        return {bus_a.out_mem_read, bus_a.out_mem_write,
                bus_a.out_mem_to_reg, bus_a.out_reg_write};
    endfunction

    initial begin
        logic [1:0] sat_exp [6];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        reset   = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        drive_a(32'h0, 32'h0, 5'd0, 4'h0);
        idle_a();
        bus_a.out_ready     = 1'b0;
        bus_b.in_valid      = 1'b0;
        bus_b.in_alu_result = 32'h0;
        bus_b.in_write_data = 32'h0;
        bus_b.in_rd         = 5'd0;
        bus_b.in_mem_read   = 1'b0;
        bus_b.in_mem_write  = 1'b0;
        bus_b.in_mem_to_reg = 1'b0;
        bus_b.in_reg_write  = 1'b0;
        bus_b.out_ready     = 1'b0;

        #3;
        chk("rst_out_valid", bus_a.out_valid, 1'b0);
        chk("rst_in_ready",  bus_a.in_ready, 1'b1);
        chk("rst_addr",      bus_a.out_mem_address, 32'h0);
        chk("rst_wdata",     bus_a.out_write_data, 32'h0);
        chk("rst_rd",        bus_a.out_rd, 5'd0);
        chk("rst_ctrl",      ctrl_a(), 4'h0);
        chk("rst_stall",     stall_a, 16'd0);
        step();
        step();
        reset = 1'b0;

        // Streaming at full rate
        bus_a.out_ready = 1'b1;
        drive_a(32'h10, 32'hA0, 5'd1, 4'b0001);
        step();
        chk("strm0_addr",  bus_a.out_mem_address, 32'h10);
        chk("strm0_rdy",   bus_a.in_ready, 1'b1);
        chk("strm0_ctrl",  ctrl_a(), 4'b0001);
        drive_a(32'h14, 32'hA4, 5'd2, 4'b0001);
        step();
        chk("strm1_addr",  bus_a.out_mem_address, 32'h14);
        chk("strm1_rdy",   bus_a.in_ready, 1'b1);
        drive_a(32'h18, 32'hA8, 5'd3, 4'b0001);
        step();
        chk("strm2_addr",  bus_a.out_mem_address, 32'h18);
        chk("strm2_wdata", bus_a.out_write_data, 32'hA8);
        chk("strm2_rdy",   bus_a.in_ready, 1'b1);
        idle_a();
        step();
        chk("strm_drain_valid", bus_a.out_valid, 1'b0);
        chk("strm_drain_ctrl",  ctrl_a(), 4'h0);
        chk("strm_stall",       stall_a, 16'd0);

        // Back-pressure into the skid; X offered while full must be ignored
        bus_a.out_ready = 1'b0;
        drive_a(32'h100, 32'h0, 5'd3, 4'b1010);
        step();
        chk("bp_a_rd",    bus_a.out_rd, 5'd3);
        chk("bp_a_rdy",   bus_a.in_ready, 1'b1);
        chk("bp_a_stall", stall_a, 16'd0);
        drive_a(32'h200, 32'h0, 5'd7, 4'b0001);
        step();
        chk("bp_two_rdy",   bus_a.in_ready, 1'b0);
        chk("bp_two_valid", bus_a.out_valid, 1'b1);
        chk("bp_two_rd",    bus_a.out_rd, 5'd3);
        chk("bp_two_addr",  bus_a.out_mem_address, 32'h100);
        chk("bp_two_stall", stall_a, 16'd1);
        drive_a(32'h3FC, 32'h0, 5'd15, 4'b0100);
        step();
        chk("bp_hold_rd",    bus_a.out_rd, 5'd3);
        chk("bp_hold_stall", stall_a, 16'd2);
        bus_a.out_ready = 1'b1;
        step();
        chk("bp_b_rd",    bus_a.out_rd, 5'd7);
        chk("bp_b_addr",  bus_a.out_mem_address, 32'h200);
        chk("bp_b_ctrl",  ctrl_a(), 4'b0001);
        chk("bp_b_rdy",   bus_a.in_ready, 1'b1);
        chk("bp_b_stall", stall_a, 16'd2);
        idle_a();
        step();
        chk("bp_empty_valid", bus_a.out_valid, 1'b0);
        chk("bp_empty_rd",    bus_a.out_rd, 5'd7);

        // Flush with both entries held
        bus_a.out_ready = 1'b0;
        drive_a(32'h40, 32'hDEAD, 5'd1, 4'b0100);
        step();
        chk("fl_a_ctrl", ctrl_a(), 4'b0100);
        drive_a(32'h44, 32'h0, 5'd2, 4'b0001);
        step();
        chk("fl_two_rdy", bus_a.in_ready, 1'b0);
        idle_a();
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk("fl_valid", bus_a.out_valid, 1'b0);
        chk("fl_ctrl",  ctrl_a(), 4'h0);
        chk("fl_rdy",   bus_a.in_ready, 1'b1);
        chk("fl_stall", stall_a, 16'd4);
        bus_a.out_ready = 1'b1;
        drive_a(32'h300, 32'h0, 5'd11, 4'b0001);
        step();
        chk("fl_c_rd",   bus_a.out_rd, 5'd11);
        chk("fl_c_addr", bus_a.out_mem_address, 32'h300);
        chk("fl_c_ctrl", ctrl_a(), 4'b0001);
        idle_a();
        step();
        chk("fl_c_drain", bus_a.out_valid, 1'b0);

        // Flush coincident with an accepted input
        drive_a(32'h900, 32'h0, 5'd9, 4'b0001);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        idle_a();
        chk("fl_d_valid", bus_a.out_valid, 1'b0);
        chk("fl_d_rd",    bus_a.out_rd, 5'd11);
        step();
        chk("fl_d_valid2", bus_a.out_valid, 1'b0);
        chk("fl_d_addr",   bus_a.out_mem_address, 32'h300);

        // Asynchronous reset while stalled
        bus_a.out_ready = 1'b0;
        drive_a(32'h500, 32'h0, 5'd5, 4'b1000);
        step();
        idle_a();
        step();
        chk("ar_pre_stall", stall_a, 16'd5);
        chk("ar_pre_ctrl",  ctrl_a(), 4'b1000);
        reset = 1'b1;
        #2;
        chk("ar_valid", bus_a.out_valid, 1'b0);
        chk("ar_ctrl",  ctrl_a(), 4'h0);
        chk("ar_stall", stall_a, 16'd0);
        chk("ar_rdy",   bus_a.in_ready, 1'b1);
        chk("ar_rd",    bus_a.out_rd, 5'd0);
        #2;
        reset = 1'b0;

        // Saturation on the 2-bit counter instance
        bus_b.in_valid      = 1'b1;
        bus_b.in_alu_result = 32'h77;
        bus_b.in_rd         = 5'd4;
        step();
        bus_b.in_valid = 1'b0;
        chk("sat_valid", bus_b.out_valid, 1'b1);
        chk("sat_0",     stall_b, 2'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("sat_%0d", i + 1), stall_b, sat_exp[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
